// File: rtl/battery_pkg.sv
// rtl/battery_pkg.sv - shared constants, band boundary function and FSM state enum
// Contents:
//   LEVEL_W / LEVEL_MAX / NUM_BANDS  bar level width, top level, number of bands
//   state_e                          estimator FSM states
//   band_bound(k, adc_w)             lower edge of band k, ceil(k * 2^adc_w / NUM_BANDS)
package battery_pkg;

  localparam int LEVEL_W   = 4;
  localparam int LEVEL_MAX = 8;
  localparam int NUM_BANDS = 9;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_AVG   = 2'd1,
    ST_EVAL  = 2'd2
  } state_e;

  // Integer ceiling division; the full ADC range is split into NUM_BANDS bands.
  function automatic int band_bound(input int k, input int adc_w);
    return (k * (1 << adc_w) + NUM_BANDS - 1) / NUM_BANDS;
  endfunction

endpackage

// File: rtl/battery_level_quantizer.sv
// rtl/battery_level_quantizer.sv - combinational band counter with hysteresis margins
// Ports:
//   avg    in   ADC_W    block average
//   level  in   LEVEL_W  current bar level
//   l_raw  out  LEVEL_W  number of bounds with avg >= B_k
//   l_up   out  LEVEL_W  number of bounds with avg >= B_k + HYST
//   l_dn   out  LEVEL_W  number of bounds with avg + HYST >= B_k
module battery_level_quantizer
  import battery_pkg::*;
#(
  parameter int ADC_W = 10,
  parameter int HYST  = 4
) (
  input  logic [ADC_W-1:0]   avg,
  input  logic [LEVEL_W-1:0] level,
  output logic [LEVEL_W-1:0] l_raw,
  output logic [LEVEL_W-1:0] l_up,
  output logic [LEVEL_W-1:0] l_dn
);

  // Comparisons run in 32-bit int so B_k + HYST and avg + HYST never wrap.
  int avg_i;
  assign avg_i = int'(avg);

  // Bands are absolute thresholds; level is carried on the port so a stateful
  // quantiser can replace this one without changing the top.
  logic unused_level;
  assign unused_level = ^level;

  always_comb begin
    l_raw = '0;
    l_up  = '0;
    l_dn  = '0;
    for (int k = 1; k <= LEVEL_MAX; k++) begin
      if (avg_i >= band_bound(k, ADC_W))        l_raw = l_raw + 4'd1;
      if (avg_i >= band_bound(k, ADC_W) + HYST) l_up  = l_up  + 4'd1;
      if (avg_i + HYST >= band_bound(k, ADC_W)) l_dn  = l_dn  + 4'd1;
    end
  end

endmodule

// File: rtl/battery_level_estimator.sv
// rtl/battery_level_estimator.sv - block-averaging ADC front end producing a 0..8 bar level
// Ports:
//   clk           in   1        system clock, rising edge
//   rst           in   1        asynchronous active-high reset
//   sample_valid  in   1        sample_data valid
//   sample_data   in   ADC_W    unsigned ADC code
//   sample_ready  out  1        high in ACCUM only
//   level         out  4        bar level 0..8
//   level_valid   out  1        one-cycle pulse per evaluation
//   low_batt      out  1        level <= LOW_LEVEL after the first evaluation
module battery_level_estimator
  import battery_pkg::*;
#(
  parameter int ADC_W     = 10,
  parameter int AVG_LOG2  = 3,
  parameter int HYST      = 4,
  parameter int LOW_LEVEL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  input  logic [ADC_W-1:0]   sample_data,
  output logic               sample_ready,
  output logic [LEVEL_W-1:0] level,
  output logic               level_valid,
  output logic               low_batt
);

  localparam int                  ACC_W    = ADC_W + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;
  localparam logic [LEVEL_W-1:0]  LOW_LVL  = LEVEL_W'(LOW_LEVEL);

  state_e               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [AVG_LOG2-1:0]  cnt_q, cnt_d;
  logic [ADC_W-1:0]     avg_q, avg_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic                 level_valid_q, level_valid_d;
  logic                 low_batt_q, low_batt_d;
  logic                 first_done_q, first_done_d;
  logic                 accept;
  logic [LEVEL_W-1:0]   l_raw, l_up, l_dn;

  battery_level_quantizer #(
    .ADC_W (ADC_W),
    .HYST  (HYST)
  ) u_quant (
    .avg   (avg_q),
    .level (level_q),
    .l_raw (l_raw),
    .l_up  (l_up),
    .l_dn  (l_dn)
  );

  assign accept = sample_valid && sample_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (accept && (cnt_q == CNT_LAST)) state_d = ST_AVG;
      ST_AVG:   state_d = ST_EVAL;
      ST_EVAL:  state_d = ST_ACCUM;
      default:  state_d = ST_ACCUM;
    endcase
  end

  always_comb begin
    sample_ready = (state_q == ST_ACCUM);
  end

  always_comb begin
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    avg_d         = avg_q;
    level_d       = level_q;
    first_done_d  = first_done_q;
    low_batt_d    = low_batt_q;
    level_valid_d = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          acc_d = acc_q + ACC_W'(sample_data);
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_AVG: begin
        avg_d = acc_q[ACC_W-1:AVG_LOG2];
        acc_d = '0;
        cnt_d = '0;
      end
      ST_EVAL: begin
        level_valid_d = 1'b1;
        first_done_d  = 1'b1;
        // First block after reset has no history to apply hysteresis against.
        if (!first_done_q)        level_d = l_raw;
        else if (l_up > level_q)  level_d = l_up;
        else if (l_dn < level_q)  level_d = l_dn;
        low_batt_d = (level_d <= LOW_LVL);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q         <= '0;
      cnt_q         <= '0;
      avg_q         <= '0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
      low_batt_q    <= 1'b0;
      first_done_q  <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      avg_q         <= avg_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
      low_batt_q    <= low_batt_d;
      first_done_q  <= first_done_d;
    end
  end

  assign level       = level_q;
  assign level_valid = level_valid_q;
  assign low_batt    = low_batt_q;

endmodule

// File: tb/tb_battery_level_estimator.sv
// tb/tb_battery_level_estimator.sv - self-checking bench for battery_level_estimator
module tb_battery_level_estimator;

  localparam int ADC_W     = 10;
  localparam int AVG_LOG2  = 3;
  localparam int HYST      = 4;
  localparam int LOW_LEVEL = 1;
  localparam int NBLK      = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             sample_valid = 1'b0;
  logic [ADC_W-1:0] sample_data = '0;
  logic             sample_ready;
  logic [3:0]       level;
  logic             level_valid;
  logic             low_batt;

  always #5 clk = ~clk;

  battery_level_estimator #(
    .ADC_W     (ADC_W),
    .AVG_LOG2  (AVG_LOG2),
    .HYST      (HYST),
    .LOW_LEVEL (LOW_LEVEL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .level        (level),
    .level_valid  (level_valid),
    .low_batt     (low_batt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int bound [1:8];
  int m_level = 0;
  bit m_first = 1'b0;

  typedef struct {
    int a;
    int na;
    int b;
    int exp_level;
    int exp_low;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: level from bar count with hysteresis margins.
  function automatic void model_eval(input int avg);
    int raw;
    int up;
    int dn;
    raw = 0; up = 0; dn = 0;
    for (int k = 1; k <= 8; k++) begin
      if (avg >= bound[k])        raw++;
      if (avg >= bound[k] + HYST) up++;
      if (avg + HYST >= bound[k]) dn++;
    end
    if (!m_first) begin
      m_level = raw;
      m_first = 1'b1;
    end else if (up > m_level) begin
      m_level = up;
    end else if (dn < m_level) begin
      m_level = dn;
    end
  endfunction

  task automatic send_block(input int a, input int na, input int b,
                            input int exp_level, input int exp_low, input string tag);
    int sum;
    int v;
    int waitn;
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      v = (i < na) ? a : b;
      sample_data  = v[ADC_W-1:0];
      sample_valid = 1'b1;
      waitn = 0;
      while (!sample_ready && waitn < 20) begin
        @(negedge clk);
        waitn++;
      end
      check({tag, "_ready_accum"}, 32'(sample_ready), 32'd1);
      @(negedge clk);
      sum += v;
    end
    sample_valid = 1'b0;
    model_eval(sum / 8);
    check({tag, "_avg_ready"}, 32'(sample_ready), 32'd0);
    check({tag, "_avg_lv"},    32'(level_valid),  32'd0);
    @(negedge clk);
    check({tag, "_eval_ready"}, 32'(sample_ready), 32'd0);
    check({tag, "_eval_lv"},    32'(level_valid),  32'd0);
    @(negedge clk);
    check({tag, "_lv"},    32'(level_valid), 32'd1);
    check({tag, "_level"}, 32'(level),       32'(exp_level));
    check({tag, "_low"},   32'(low_batt),    32'(exp_low));
    check({tag, "_model"}, 32'(level),       32'(m_level));
    @(negedge clk);
    check({tag, "_lv_drop"},  32'(level_valid),  32'd0);
    check({tag, "_ready_up"}, 32'(sample_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"}, 32'(level),        32'd0);
    check({tag, "_lv"},    32'(level_valid),  32'd0);
    check({tag, "_low"},   32'(low_batt),     32'd0);
    check({tag, "_ready"}, 32'(sample_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sum;
    int base;
    int v;
    int phase;

    for (int k = 1; k <= 8; k++)
      bound[k] = int'($ceil(real'(k) * real'(2 ** ADC_W) / 9.0));

    tbl[0] = '{500,  8, 0,   4, 0};
    tbl[1] = '{571,  8, 0,   4, 0};
    tbl[2] = '{573,  8, 0,   5, 0};
    tbl[3] = '{566,  8, 0,   5, 0};
    tbl[4] = '{564,  8, 0,   4, 0};
    tbl[5] = '{400,  4, 600, 4, 0};
    tbl[6] = '{100,  7, 107, 0, 1};
    tbl[7] = '{1023, 8, 0,   8, 0};

    // Asynchronous reset with no clock edge in between.
    #1 rst = 1'b1;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    check_reset_outputs("por_held");
    rst = 1'b0;
    m_first = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      send_block(tbl[i].a, tbl[i].na, tbl[i].b, tbl[i].exp_level, tbl[i].exp_low,
                 $sformatf("tbl%0d", i));

    // Valid held high through AVG/EVAL with data changing every cycle.
    sum = 0;
    base = 0;
    for (int c = 0; c <= NBLK * 10; c++) begin
      phase = c % 10;
      if (c == NBLK * 10) begin
        sample_valid = 1'b0;
      end else begin
        if (phase == 0) base = int'($urandom_range(0, 1023));
        v = base + int'($urandom_range(0, 16)) - 8;
        if (v < 0)    v = 0;
        if (v > 1023) v = 1023;
        sample_valid = 1'b1;
        sample_data  = v[ADC_W-1:0];
      end
      check($sformatf("bp_ready_c%0d", c), 32'(sample_ready), 32'(phase < 8));
      check($sformatf("bp_lv_c%0d", c), 32'(level_valid), 32'((c > 0) && (phase == 0)));
      if (c > 0 && phase == 0) begin
        check($sformatf("bp_level_c%0d", c), 32'(level),    32'(m_level));
        check($sformatf("bp_low_c%0d", c),   32'(low_batt), 32'(m_level <= LOW_LEVEL));
      end
      if (c < NBLK * 10) begin
        if (phase < 8) sum += v;
        if (phase == 7) begin
          model_eval(sum / 8);
          sum = 0;
        end
        @(negedge clk);
      end
    end

    // Partial block then asynchronous reset mid-cycle.
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1;
      sample_data  = 10'd1000;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    check_reset_outputs("midrst_held");
    rst = 1'b0;
    m_first = 1'b0;
    @(negedge clk);
    send_block(300, 8, 0, 2, 0, "rst300");

    // From level 8, a fresh reset must take L_raw=2 for 340 rather than L_dn=3.
    send_block(1023, 8, 0, 8, 0, "top");
    rst = 1'b1;
    #3 rst = 1'b0;
    m_first = 1'b0;
    @(negedge clk);
    send_block(340, 8, 0, 2, 0, "rst340");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/battery_level_estimator.md
Name: battery_level_estimator

Overview:
Upstream stage of battery_led_bar. Accepts raw battery-voltage ADC samples over a valid/ready handshake and averages them in blocks of 2^AVG_LOG2. Each block average is quantised to a bar level 0..8 with hysteresis. Drives the 4-bit level consumed by the LED bar, plus an update strobe and a low-battery flag.

Parameters:
ADC_W, 10, ADC sample width in bits; 8..12 supported
AVG_LOG2, 3, log2 of samples per average block; 1..6
HYST, 4, hysteresis margin in ADC counts; must be less than half of one band width
LOW_LEVEL, 1, low_batt asserts when level <= LOW_LEVEL

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
sample_valid  in  1  sample_data is valid this cycle
sample_data  in  ADC_W  unsigned ADC code
sample_ready  out  1  block can accept a sample this cycle
level  out  4  bar level 0..8, feeds battery_led_bar
level_valid  out  1  one-cycle pulse when level is (re)evaluated
low_batt  out  1  battery-low indicator

Behaviour:
- Reset (async assert, values held while rst=1): level=0, level_valid=0, low_batt=0, sample_ready=1. Also clears the accumulator, the sample counter and first_done. State goes to ACCUM.
- FSM has three states: ACCUM, AVG, EVAL.
- ACCUM: sample_ready=1. A sample is accepted on a cycle where sample_valid and sample_ready are both 1. Each accepted sample is added to an (ADC_W+AVG_LOG2)-bit accumulator, so there is no overflow. The counter counts 0..2^AVG_LOG2-1. The accept that brings the count to 2^AVG_LOG2 moves the FSM to AVG.
- AVG: sample_ready=0. Register avg = acc >> AVG_LOG2, which truncates. Clear acc and count. Go to EVAL.
- EVAL: sample_ready=0. Update level, pulse level_valid for 1 cycle, update low_batt. Go to ACCUM.
- Latency: last sample accepted at edge t -> new level and level_valid=1 visible after edge t+2. Throughput is 2^AVG_LOG2+2 cycles per update when valid is held high.
- While sample_ready=0, sample_valid is ignored. The source must hold its data; no sample is lost or double-counted.
- Band boundaries: B_k = ceil(k * 2^ADC_W / 9) for k=1..8. For ADC_W=10 these are 114, 228, 342, 456, 569, 683, 797, 911.
- Quantiser (all comparisons unsigned, on widened arithmetic with no wrap):
  - L_raw = #{k : avg >= B_k}
  - L_up = #{k : avg >= B_k + HYST}
  - L_dn = #{k : avg + HYST >= B_k}
  - Ordering always holds: L_up <= L_raw <= L_dn.
- Level update in EVAL:
  - First EVAL after reset (first_done=0): level = L_raw, then set first_done.
  - Otherwise, if L_up > level: level = L_up (multi-step jumps allowed).
  - Else if L_dn < level: level = L_dn.
  - Else: hold.
- low_batt = first_done && (level <= LOW_LEVEL). It is registered and updates only in EVAL.
- level stays in 0..8 at all times. Values 9..15 are never produced.
- Reset mid-block: any partial accumulation is discarded, and the first completed block after reset uses L_raw.

Decomposition:
- Package battery_pkg holds the shared constants and the boundary function:
  - LEVEL_W=4, LEVEL_MAX=8, NUM_BANDS=9.
  - Function band_bound(k, adc_w) returning B_k, shared with any future battery-monitor blocks.
  - FSM state enum.
- One sub-module, battery_level_quantizer: purely combinational. Inputs are avg and the current level (parameters ADC_W, HYST). Outputs are L_raw, L_up and L_dn. The top module keeps the FSM, the accumulator and the output registers.

Test Plan (ADC_W=10, AVG_LOG2=3, HYST=4, LOW_LEVEL=1):
- Reset, then 8 samples of 500 -> level=4 with a single level_valid pulse 2 cycles after the 8th accept; low_batt=0. During those 2 cycles sample_ready=0.
- From level 4: a block of 571 -> level stays 4 (571 < 573) with a pulse; then a block of 573 -> level=5.
- From level 5: a block of 566 -> stays 5 (566+4 >= 569); then a block of 564 -> level=4.
- Averaging/saturation:
  - 4x400 then 4x600 -> avg 500, level 4.
  - 7x100 plus 1x107 -> avg 100 (truncation), level 0, low_batt=1.
  - 8x1023 -> level 8 (jump from 0 in one update).
- Backpressure: sample_valid held high through AVG/EVAL with changing data -> exactly 8 accepts per block, updates every 10 cycles, and the stalled data is not counted.
- Reset asserted asynchronously after 5 accepted samples of 1000, then 8x300 -> level=2 with no hysteresis applied; outputs are 0 during reset.
